// File: rtl/wide_op_driver.sv
// Wide-adder initiator: loads op1/op2 from a narrow beat stream, fires the adder for one cycle,
// waits LAT cycles, captures res and streams it back. Optional self-check: WIDE_OP_DRIVER_CHECK_EN.
//
// state   | meaning
// LOAD_A  | accept op1 beats, LSB beat first
// LOAD_B  | accept op2 beats, LSB beat first
// ISSUE   | one-cycle adder enable (en1 + en2 = 8'hFF)
// WAIT    | capture-latency countdown, res sampled on terminal count
// DRAIN   | return result beats, done on the last handshake
module wide_op_driver #(
   parameter int WIDTH = 256,
   parameter int BEAT  = 32,
   parameter int LAT   = 2
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [BEAT-1:0]  in_data,
   output logic [WIDTH-1:0] op1,
   output logic [WIDTH-1:0] op2,
   output logic [7:0]       en1,
   output logic [7:0]       en2,
   input  logic [WIDTH-1:0] res,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [BEAT-1:0]  out_data,
   output logic             done,
   output logic             busy,
   output logic             mismatch
);
   localparam int NB  = WIDTH / BEAT;
   localparam int BCW = (NB > 1) ? $clog2(NB) : 1;
   localparam int WCW = (LAT > 1) ? $clog2(LAT) : 1;
   localparam logic [BCW-1:0] LAST_BEAT = BCW'(NB - 1);
   localparam logic [WCW-1:0] WAIT_LOAD = WCW'(LAT - 1);

   typedef enum logic [2:0] {LOAD_A, LOAD_B, ISSUE, WAIT, DRAIN} state_t;

   state_t           state_q, state_d;
   logic [BCW-1:0]   beat_q;
   logic [WCW-1:0]   wait_q;
   logic [WIDTH-1:0] result_q;
   logic             accept, last_beat, capture, drain_hs;

   assign last_beat = (beat_q == LAST_BEAT);

   always_comb begin
      state_d   = state_q;
      in_ready  = 1'b0;
      en1       = 8'h00;
      en2       = 8'h00;
      out_valid = 1'b0;
      done      = 1'b0;
      busy      = 1'b1;
      accept    = 1'b0;
      capture   = 1'b0;
      drain_hs  = 1'b0;
      case (state_q)
         LOAD_A: begin
            in_ready = 1'b1;
            busy     = 1'b0;
            accept   = in_valid;
            if (accept && last_beat) state_d = LOAD_B;
         end
         LOAD_B: begin
            in_ready = 1'b1;
            accept   = in_valid;
            if (accept && last_beat) state_d = ISSUE;
         end
         ISSUE: begin
            en1     = 8'hFF;
            state_d = WAIT;
         end
         WAIT: begin
            if (wait_q == '0) begin
               capture = 1'b1;
               state_d = DRAIN;
            end
         end
         DRAIN: begin
            out_valid = 1'b1;
            drain_hs  = out_ready;
            if (drain_hs && last_beat) begin
               done    = 1'b1;
               state_d = LOAD_A;
            end
         end
         default: state_d = LOAD_A;
      endcase
   end

   // One beat counter serves loading and draining; it is back at 0 after every wrap.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q  <= LOAD_A;
         beat_q   <= '0;
         wait_q   <= '0;
         op1      <= '0;
         op2      <= '0;
         result_q <= '0;
      end else begin
         state_q <= state_d;
         if (accept) begin
            if (state_q == LOAD_A) op1[BEAT*int'(beat_q) +: BEAT] <= in_data;
            else                   op2[BEAT*int'(beat_q) +: BEAT] <= in_data;
         end
         if (accept || drain_hs) beat_q <= last_beat ? '0 : beat_q + 1'b1;
         if (state_q == ISSUE)                wait_q <= WAIT_LOAD;
         else if (state_q == WAIT && !capture) wait_q <= wait_q - 1'b1;
         if (capture) result_q <= res;
      end
   end

   assign out_data = out_valid ? result_q[BEAT*int'(beat_q) +: BEAT] : '0;

`ifdef WIDE_OP_DRIVER_CHECK_EN
   logic [WIDTH-1:0] expect_sum;
   logic             mismatch_q;

   assign expect_sum = op1 + op2;

   always_ff @(posedge clk) begin
      if (!rst_n)                           mismatch_q <= 1'b0;
      else if (capture && res != expect_sum) mismatch_q <= 1'b1;
   end

   assign mismatch = mismatch_q;
`else
   assign mismatch = 1'b0;
`endif

endmodule

// File: tb/tb_wide_op_driver.sv
// Randomized bench for wide_op_driver: transaction-level reference model checked every cycle,
// plus literal expectations for the directed cases. Honours WIDE_OP_DRIVER_CHECK_EN.
module tb_wide_op_driver;
   localparam int WIDTH = 256;
   localparam int BEAT  = 32;
   localparam int LAT   = 2;
   localparam int NB    = WIDTH / BEAT;
`ifdef WIDE_OP_DRIVER_CHECK_EN
   localparam bit CHK = 1'b1;
`else
   localparam bit CHK = 1'b0;
`endif

   logic             clk = 1'b0;
   logic             rst_n = 1'b0;
   logic             in_valid = 1'b0;
   logic             in_ready;
   logic [BEAT-1:0]  in_data = '0;
   logic [WIDTH-1:0] op1, op2;
   logic [7:0]       en1, en2;
   logic [WIDTH-1:0] res = '0;
   logic             out_valid;
   logic             out_ready = 1'b0;
   logic [BEAT-1:0]  out_data;
   logic             done, busy, mismatch;

   wide_op_driver #(.WIDTH(WIDTH), .BEAT(BEAT), .LAT(LAT)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
      .op1(op1), .op2(op2), .en1(en1), .en2(en2), .res(res), .out_valid(out_valid),
      .out_ready(out_ready), .out_data(out_data), .done(done), .busy(busy), .mismatch(mismatch)
   );

   always #5 clk = ~clk;

   int  n_cmp = 0;
   int  n_err = 0;
   bit  chk_en = 1'b0;
   logic corrupt = 1'b0;
   logic [BEAT-1:0] got[$];

   task automatic check(input string nm, input logic [WIDTH-1:0] act, input logic [WIDTH-1:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   // Adder stage stand-in: fires on the opposite edge whenever the enable terms sum to all-ones.
   logic [7:0] en_sum;
   assign en_sum = en1 + en2;
   always @(negedge clk)
      if (en_sum == 8'hFF) res <= (op1 + op2) ^ {{(WIDTH-1){1'b0}}, corrupt};

   // Reference model: beats loaded so far, cycles since loading finished, beats drained.
   int m_load = 0, m_post = 0, m_j = 0;
   logic [WIDTH-1:0] m_a = '0, m_b = '0, m_res = '0;
   logic m_mis = 1'b0;

   always @(posedge clk) begin
      if (!rst_n) begin
         m_load = 0; m_post = 0; m_j = 0;
         m_a = '0; m_b = '0; m_res = '0; m_mis = 1'b0;
      end else if (m_load < 2*NB) begin
         if (in_valid) begin
            if (m_load < NB) m_a[BEAT*m_load +: BEAT] = in_data;
            else             m_b[BEAT*(m_load-NB) +: BEAT] = in_data;
            m_load++;
         end
      end else if (m_post <= LAT) begin
         if (m_post == LAT) begin
            m_res = (m_a + m_b) ^ {{(WIDTH-1){1'b0}}, corrupt};
            if (CHK && corrupt) m_mis = 1'b1;
         end
         m_post++;
      end else if (out_ready) begin
         if (m_j == NB-1) begin
            m_load = 0; m_post = 0; m_j = 0;
         end else begin
            m_j++;
         end
      end
   end

   logic e_load, e_issue, e_drain;
   always @(negedge clk) begin
      if (chk_en) begin
         e_load  = (m_load < 2*NB);
         e_issue = !e_load && m_post == 0;
         e_drain = !e_load && m_post == LAT+1;
         check("in_ready",  WIDTH'(in_ready),  WIDTH'(e_load));
         check("busy",      WIDTH'(busy),      WIDTH'(m_load >= NB));
         check("en1",       WIDTH'(en1),       e_issue ? WIDTH'(8'hFF) : '0);
         check("en2",       WIDTH'(en2),       '0);
         check("out_valid", WIDTH'(out_valid), WIDTH'(e_drain));
         check("done",      WIDTH'(done),      WIDTH'(e_drain && out_ready && m_j == NB-1));
         check("op1",       op1,               m_a);
         check("op2",       op2,               m_b);
         check("mismatch",  WIDTH'(mismatch),  WIDTH'(m_mis));
         if (e_drain) check("out_data", WIDTH'(out_data), WIDTH'(m_res[BEAT*m_j +: BEAT]));
      end
   end

   function automatic logic [WIDTH-1:0] gathered();
      logic [WIDTH-1:0] r = '1;
      for (int i = 0; i < NB && i < got.size(); i++) r[BEAT*i +: BEAT] = got[i];
      return r;
   endfunction

   task automatic run_txn(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                          input int bp, input int iv_pct, output int lat);
      int idx = 0, first = -1, cyc = 0;
      bit finished = 1'b0;
      got.delete();
      lat = -1;
      while (!finished && cyc < 400) begin
         if (idx < 2*NB) begin
            in_valid = (int'($urandom_range(99)) < iv_pct);
            in_data  = (idx < NB) ? a[BEAT*idx +: BEAT] : b[BEAT*(idx-NB) +: BEAT];
         end else begin
            in_valid = 1'($urandom_range(1));
            in_data  = BEAT'($urandom);
         end
         case (bp)
            0:       out_ready = 1'b1;
            1:       out_ready = (cyc % 3 == 0);
            default: out_ready = 1'($urandom_range(1));
         endcase
         @(negedge clk);
         if (in_valid && in_ready) begin
            if (idx == 0) first = cyc;
            idx++;
         end
         if (out_valid && out_ready) got.push_back(out_data);
         if (done) begin
            lat = cyc - first + 1;
            finished = 1'b1;
         end
         @(posedge clk); #1;
         cyc++;
      end
      in_valid  = 1'b0;
      out_ready = 1'b0;
      if (!finished) begin
         n_cmp++; n_err++;
         $display("FAIL txn_timeout: no done after %0d cycles, required a done pulse", cyc);
      end
   endtask

   initial begin
      int lat;
      logic [WIDTH-1:0] a, b;

      rst_n = 1'b0;
      @(posedge clk); #1;
      chk_en = 1'b1;
      @(posedge clk); #1;
      check("rst_in_ready", WIDTH'(in_ready), WIDTH'(1));
      check("rst_busy",     WIDTH'(busy),     '0);
      check("rst_out_data", WIDTH'(out_data), '0);
      rst_n = 1'b1;

      run_txn(256'd1, 256'd2, 0, 100, lat);
      check("basic_latency", WIDTH'(lat), WIDTH'(27));
      check("basic_beats",   WIDTH'(got.size()), WIDTH'(NB));
      check("basic_result",  gathered(), 256'd3);

      run_txn(256'h0000_0000_FFFF_FFFF, 256'd1, 0, 100, lat);
      check("carry_result", gathered(), 256'h1_0000_0000);

      run_txn('1, 256'd1, 0, 100, lat);
      check("wrap_result", gathered(), '0);
      check("wrap_mismatch", WIDTH'(mismatch), '0);

      a = {8{32'h1357_9BDF}};
      b = {8{32'h0246_8ACE}};
      run_txn(a, b, 1, 100, lat);
      check("bp_beats",  WIDTH'(got.size()), WIDTH'(NB));
      check("bp_result", gathered(), {8{32'h159E_26AD}});

      // Reset during the first WAIT cycle discards the pending capture.
      for (int i = 0; i < 2*NB; i++) begin
         in_valid = 1'b1;
         in_data  = BEAT'($urandom);
         @(posedge clk); #1;
      end
      in_valid = 1'b0;
      @(posedge clk); #1;
      rst_n = 1'b0;
      @(posedge clk); #1;
      rst_n = 1'b1;
      check("rstw_busy",      WIDTH'(busy),      '0);
      check("rstw_en1",       WIDTH'(en1),       '0);
      check("rstw_out_valid", WIDTH'(out_valid), '0);
      check("rstw_in_ready",  WIDTH'(in_ready),  WIDTH'(1));
      run_txn(256'd5, 256'd7, 0, 100, lat);
      check("rstw_result", gathered(), 256'd12);

      corrupt = 1'b1;
      run_txn(256'd10, 256'd20, 0, 100, lat);
      corrupt = 1'b0;
      check("bad_result",   gathered(), 256'd31);
      check("bad_mismatch", WIDTH'(mismatch), WIDTH'(CHK));
      run_txn(256'd4, 256'd4, 0, 100, lat);
      check("sticky_mismatch", WIDTH'(mismatch), WIDTH'(CHK));
      rst_n = 1'b0;
      @(posedge clk); #1;
      rst_n = 1'b1;
      check("cleared_mismatch", WIDTH'(mismatch), '0);

      for (int t = 0; t < 20; t++) begin
         for (int k = 0; k < NB; k++) begin
            a[BEAT*k +: BEAT] = BEAT'($urandom);
            b[BEAT*k +: BEAT] = BEAT'($urandom);
         end
         if (t % 5 == 0) a = '1;
         run_txn(a, b, int'($urandom_range(2)), int'($urandom_range(100, 30)), lat);
         check("rand_result", gathered(), a + b);
      end

      chk_en = 1'b0;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
